// File: rtl/r200_fetchq.sv
// r200_fetchq -- instruction fetch queue between instruction memory and IF/ID.
//
// Issues at most one instruction-memory read at a time. Each accepted word is
// stored with its address and address+4 in a DEPTH-entry circular queue. A
// redirect flushes the queue and restarts fetching at the new target. A
// response still owed for a request made before a redirect (or before a
// reset) is absorbed in the DROP state and never reaches the outputs.
//
// Parameters
//   DEPTH     queue entries, power of two in 2..16
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   redirect, redirect_pc    pipeline redirect and its target
//   imem_req, imem_addr      memory read request and word-aligned address
//   imem_ack, imem_rdata     read response (may arrive in the request cycle)
//   out_valid, out_ready     head-entry handshake toward IF/ID
//   out_instrn/pc/pcp4       head instruction, its address, address+4
//   occupancy                number of valid queue entries
//
// Build option
//   R200_FETCHQ_BYPASS_EN    when defined, an accepted response arriving at an
//                            empty queue is presented on out_* in the same
//                            cycle, and consumed without being queued if
//                            out_ready is high.

module r200_fetchq #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instrn,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcp4,
  output logic [4:0]  occupancy
);

  localparam int          PW          = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_W     = 5'(DEPTH);
  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pcp4;
  logic [PW-1:0] head, tail;
  logic [4:0]    count, count_next;
  logic          accept, push, pop;

  logic [31:0]   q_instrn [DEPTH];
  logic [31:0]   q_pc     [DEPTH];
  logic [31:0]   q_pcp4   [DEPTH];

  // The low target bits are dropped by word alignment.
  logic          unused_bits;
  assign unused_bits = ^redirect_pc[1:0];

  assign fetch_pcp4 = fetch_pc + 32'd4;
  assign imem_req   = (state == REQ);
  assign imem_addr  = fetch_pc;
  assign occupancy  = count;

  // A response is kept only for a live request with no redirect or reset
  // in the same cycle.
  assign accept = imem_req && imem_ack && !redirect && !rst;
  assign pop    = (count != 5'd0) && out_ready;

`ifdef R200_FETCHQ_BYPASS_EN
  logic bypass;
  assign bypass     = accept && (count == 5'd0);
  assign out_valid  = (count != 5'd0) || bypass;
  assign out_instrn = bypass ? imem_rdata : q_instrn[head];
  assign out_pc     = bypass ? fetch_pc   : q_pc[head];
  assign out_pcp4   = bypass ? fetch_pcp4 : q_pcp4[head];
  // A bypassed word taken immediately never occupies an entry.
  assign push       = accept && !(bypass && out_ready);
`else
  assign out_valid  = (count != 5'd0);
  assign out_instrn = q_instrn[head];
  assign out_pc     = q_pc[head];
  assign out_pcp4   = q_pcp4[head];
  assign push       = accept;
`endif

  always_comb begin
    count_next = count;
    if (redirect)
      count_next = 5'd0;
    else
      count_next = count + {4'b0, push} - {4'b0, pop};
  end

  // A new request is only allowed when the entry it will fill is guaranteed
  // free, so the next-cycle occupancy decides every transition into REQ.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (count_next < DEPTH_W) state_next = REQ;
      REQ: begin
        if (imem_ack)
          state_next = (count_next < DEPTH_W) ? REQ : IDLE;
        else if (redirect)
          state_next = DROP;
      end
      DROP: if (imem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A request left unanswered by reset still gets a response from memory,
  // so reset parks the FSM in DROP until that response has been absorbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ((state == REQ || state == DROP) && !imem_ack) ? DROP : IDLE;
      count    <= 5'd0;
      head     <= '0;
      tail     <= '0;
      fetch_pc <= RESET_PC_AL;
      for (int i = 0; i < DEPTH; i++) begin
        q_instrn[i] <= '0;
        q_pc[i]     <= '0;
        q_pcp4[i]   <= '0;
      end
    end else begin
      state <= state_next;
      count <= count_next;
      if (redirect) begin
        head     <= '0;
        tail     <= '0;
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else begin
        if (push) begin
          q_instrn[tail] <= imem_rdata;
          q_pc[tail]     <= fetch_pc;
          q_pcp4[tail]   <= fetch_pcp4;
          tail           <= tail + PW'(1);
        end
        if (pop)
          head <= head + PW'(1);
        if (accept)
          fetch_pc <= fetch_pcp4;
      end
    end
  end

endmodule

// File: tb/tb_r200_fetchq.sv
// Testbench for r200_fetchq: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model of the fetch
// stream (expected address sequence, queue fill level, stale responses).

module tb_r200_fetchq;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
`ifdef R200_FETCHQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instrn;
  logic [31:0] out_pc;
  logic [31:0] out_pcp4;
  logic [4:0]  occupancy;

  r200_fetchq #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instrn(out_instrn), .out_pc(out_pc), .out_pcp4(out_pcp4),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: one outstanding read, answered after mem_lat cycles.
  bit          mem_busy   = 1'b0;
  bit          mem_stale  = 1'b0;
  logic [31:0] mem_addr_l = '0;
  int          mem_cnt    = 0;
  int          mem_lat    = 0;
  bit          lat_random = 1'b0;
  int          lat_fixed  = 0;

  // Stream model: fill level, next address to be delivered, next address
  // expected on a fresh request.
  int          exp_occ    = 0;
  logic [31:0] exp_pc     = RESET_PC;
  logic [31:0] exp_req_pc = RESET_PC;

  bit          prev_req_hold = 1'b0;
  logic [31:0] prev_addr     = '0;
  bit          prev_stall    = 1'b0;
  logic [31:0] prev_pc = '0, prev_pcp4 = '0, prev_instrn = '0;

  logic        s_req, s_valid, s_ack, s_delivered, s_new_req;
  logic [31:0] s_addr, s_pc, s_pcp4, s_instrn;
  logic [4:0]  s_occ;

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [4:0]  exp_occ;
  } vec_t;
  vec_t vecs [5];

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h0050_0093 : {a[15:0], ~a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, answer memory, sample
  // and check outputs, advance the models, then wait for the next edge.
  task automatic applyStimulus(input logic r, input logic rdy,
                               input logic redir, input logic [31:0] tgt);
    logic ack_now, accepted, byp, exp_valid, delivered;
    rst = r; out_ready = rdy; redirect = redir; redirect_pc = tgt;
    ack_now = 1'b0;
    s_new_req = 1'b0;
    if (!mem_busy && imem_req) begin
      mem_busy = 1'b1; mem_addr_l = imem_addr; mem_cnt = 0; mem_stale = 1'b0;
      mem_lat = lat_random ? int'($urandom_range(0, 3)) : lat_fixed;
      s_new_req = 1'b1;
      checkOutput("req_addr", imem_addr, exp_req_pc);
    end
    if (mem_busy && mem_cnt >= mem_lat) ack_now = 1'b1;
    imem_ack   = ack_now;
    imem_rdata = ack_now ? instrOf(mem_addr_l) : $urandom();
    #1;
    accepted  = ack_now && !mem_stale && !redir && !r;
    byp       = BYPASS && accepted && (exp_occ == 0);
    exp_valid = (exp_occ != 0) || byp;
    delivered = exp_valid && rdy && !redir && !r;
    if (prev_req_hold) begin
      checkOutput("req_hold", 32'(imem_req), 32'd1);
      checkOutput("addr_hold", imem_addr, prev_addr);
    end
    if (prev_stall) begin
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_pc", out_pc, prev_pc);
      checkOutput("stall_pcp4", out_pcp4, prev_pcp4);
      checkOutput("stall_instrn", out_instrn, prev_instrn);
    end
    if (!r) begin
      checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
      checkOutput("occupancy", 32'(occupancy), 32'(exp_occ));
      checkOutput("space_rule", 32'(int'(occupancy) + int'(imem_req) <= DEPTH), 32'd1);
      if (imem_req) checkOutput("addr_align", 32'(imem_addr[1:0]), 32'd0);
      if (exp_valid) begin
        checkOutput("head_pc", out_pc, exp_pc);
        checkOutput("head_pcp4", out_pcp4, exp_pc + 32'd4);
        checkOutput("head_instrn", out_instrn, instrOf(exp_pc));
      end
    end
    s_req = imem_req; s_addr = imem_addr; s_valid = out_valid; s_ack = ack_now;
    s_pc = out_pc; s_pcp4 = out_pcp4; s_instrn = out_instrn; s_occ = occupancy;
    s_delivered = delivered;
    prev_req_hold = !r && imem_req && !ack_now && !redir;
    prev_addr     = imem_addr;
    prev_stall    = !r && exp_valid && !rdy && !redir;
    prev_pc = out_pc; prev_pcp4 = out_pcp4; prev_instrn = out_instrn;
    if (r) begin
      exp_occ = 0; exp_pc = RESET_PC; exp_req_pc = RESET_PC;
    end else if (redir) begin
      exp_occ = 0; exp_pc = {tgt[31:2], 2'b00}; exp_req_pc = {tgt[31:2], 2'b00};
    end else begin
      if (delivered) exp_pc = exp_pc + 32'd4;
      exp_occ = exp_occ + ((accepted && !(byp && rdy)) ? 1 : 0)
                        - (((exp_occ != 0) && rdy) ? 1 : 0);
      if (accepted) exp_req_pc = exp_req_pc + 32'd4;
    end
    if (ack_now) mem_busy = 1'b0;
    else if (mem_busy) begin
      mem_cnt++;
      if (r || redir) mem_stale = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Hold reset until no memory response is still owed, then check the
  // registered reset state.
  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      if (!mem_busy) break;
    end
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_occ", 32'(occupancy), 32'd0);
    checkOutput("rst_pc", out_pc, 32'd0);
    checkOutput("rst_pcp4", out_pcp4, 32'd0);
    checkOutput("rst_instrn", out_instrn, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic        found;
    logic [31:0] pc1, pc2, p41, p42;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0;
    imem_rdata = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Straight-line fetch after reset, zero-wait memory, IF/ID always ready.
    if (BYPASS) begin
      vecs[0] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   5'd0};
      vecs[1] = '{1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 5'd0};
      vecs[2] = '{1'b1, 1'b1, 32'h104, 1'b1, 32'h104, 5'd0};
      vecs[3] = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h108, 5'd0};
      vecs[4] = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h10C, 5'd0};
    end else begin
      vecs[0] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   5'd0};
      vecs[1] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   5'd0};
      vecs[2] = '{1'b1, 1'b1, 32'h104, 1'b1, 32'h100, 5'd1};
      vecs[3] = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h104, 5'd1};
      vecs[4] = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h108, 5'd1};
    end
    lat_random = 1'b0; lat_fixed = 0;
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, vecs[i].rdy, 1'b0, 32'h0);
      checkOutput($sformatf("vec%0d_req", i), 32'(s_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req)
        checkOutput($sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_occ", i), 32'(s_occ), 32'(vecs[i].exp_occ));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("vec%0d_pc", i), s_pc, vecs[i].exp_pc);
        checkOutput($sformatf("vec%0d_instrn", i), s_instrn, instrOf(vecs[i].exp_pc));
      end
    end

`ifdef R200_FETCHQ_BYPASS_EN
    // Bypass of the first word into an empty queue.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("byp_valid", 32'(s_valid), 32'd1);
    checkOutput("byp_instrn", s_instrn, 32'h0050_0093);
    checkOutput("byp_occ", 32'(s_occ), 32'd0);
`endif

    // Stall for ten cycles: queue fills, requests stop, then drains in order.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("stall_full_occ", 32'(s_occ), 32'd4);
    checkOutput("stall_full_req", 32'(s_req), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      if (s_new_req) found = 1'b1;
    end
    checkOutput("resume_found", 32'(found), 32'd1);
    checkOutput("resume_addr", s_addr, 32'h110);

    // Redirect while a slow response is pending.
    doReset();
    lat_fixed = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      if (s_new_req) found = 1'b1;
    end
    checkOutput("slow_req_found", 32'(found), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h2002);
    checkOutput("slow_redir_noack", 32'(s_ack), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      if (s_new_req) found = 1'b1;
    end
    checkOutput("slow_newreq_found", 32'(found), 32'd1);
    checkOutput("slow_newreq_addr", s_addr, 32'h2000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      if (s_delivered) found = 1'b1;
    end
    checkOutput("slow_deliv_found", 32'(found), 32'd1);
    checkOutput("slow_first_pc", s_pc, 32'h2000);

    // Redirect coincident with an ack and a pop.
    doReset();
    lat_fixed = 0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h3000);
    checkOutput("coin_ack", 32'(s_ack), 32'd1);
    checkOutput("coin_valid", 32'(s_valid), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("coin_e1_occ", 32'(s_occ), 32'd0);
    checkOutput("coin_e1_req", 32'(s_req), 32'd1);
    checkOutput("coin_e1_addr", s_addr, 32'h3000);
    checkOutput("coin_e1_valid", 32'(s_valid), 32'(BYPASS));
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("coin_e2_valid", 32'(s_valid), 32'd1);
    checkOutput("coin_e2_pc", s_pc, BYPASS ? 32'h3004 : 32'h3000);

    // Address wrap at the top of the address space.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_e1_addr", s_addr, 32'hFFFF_FFFC);
    pc1 = s_pc; p41 = s_pcp4;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_e2_req", 32'(s_req), 32'd1);
    checkOutput("wrap_e2_addr", s_addr, 32'h0);
    pc2 = s_pc; p42 = s_pcp4;
    checkOutput("wrap_pc", BYPASS ? pc1 : pc2, 32'hFFFF_FFFC);
    checkOutput("wrap_pcp4", BYPASS ? p41 : p42, 32'h0);

    // Randomized traffic: latency, stalls, redirects and occasional resets.
    lat_random = 1'b1;
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 19) == 0, $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
